// File: rtl/reg_file.sv
// MIPS R2000 general-purpose register file: 32 x 32-bit, two combinational
// read ports with write-first bypass, one synchronous write port, $0 tied to zero.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] SP_INIT    = 32'h0000_7FFC,
  parameter logic [31:0] GP_INIT    = 32'h0000_1800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            read_reg_1,
  input  logic [4:0]            read_reg_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic [4:0]            write_register,
  input  logic [DATA_WIDTH-1:0] write_data_reg,
  input  logic                  reg_write,
  output logic [31:0]           write_count
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned GP_IDX   = 28;
  localparam int unsigned SP_IDX   = 29;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_ok;
  logic                  bypass_ok;

  assign write_ok  = reg_write && (write_register != 5'd0);
  assign bypass_ok = write_ok && !rst;

  // Reset wins over a simultaneous write; writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == GP_IDX)      regs[i] <= DATA_WIDTH'(GP_INIT);
        else if (i == SP_IDX) regs[i] <= DATA_WIDTH'(SP_INIT);
        else                  regs[i] <= '0;
      end
      write_count <= 32'd0;
    end else if (write_ok) begin
      regs[write_register] <= write_data_reg;
      write_count          <= write_count + 32'd1;
    end
  end

  // Read ports: $0 reads zero, a matching in-flight write is forwarded.
  always_comb begin
    read_data_1 = regs[read_reg_1];
    if (read_reg_1 == 5'd0)
      read_data_1 = '0;
    else if (bypass_ok && (write_register == read_reg_1))
      read_data_1 = write_data_reg;
  end

  always_comb begin
    read_data_2 = regs[read_reg_2];
    if (read_reg_2 == 5'd0)
      read_data_2 = '0;
    else if (bypass_ok && (write_register == read_reg_2))
      read_data_2 = write_data_reg;
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reset readout, directed vector table,
// randomized traffic against an array model, and a counter-wrap check.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg_1, read_reg_2, write_register;
  logic [31:0] read_data_1, read_data_2, write_data_reg, write_count;
  logic        reg_write;

  int checks   = 0;
  int failures = 0;

  reg_file dut (
    .clk(clk), .rst(rst),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_register(write_register), .write_data_reg(write_data_reg),
    .reg_write(reg_write), .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] expcnt;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] model [32];
  logic [31:0] model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge; outputs settle before the next rising edge.
  task automatic drive(input logic r, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; reg_write = we; write_register = wr; write_data_reg = wd;
    read_reg_1 = a; read_reg_2 = b;
    #1;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (!rst && reg_write && write_register == idx) return write_data_reg;
    return model[idx];
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (model[i]) model[i] = 32'd0;
      model[28] = 32'h0000_1800;
      model[29] = 32'h0000_7FFC;
      model_cnt = 32'd0;
    end else if (reg_write && write_register != 5'd0) begin
      model[write_register] = write_data_reg;
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd28, 5'd29, 32'h0000_1800, 32'h0000_7FFC, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 5'd31, 32'h1234_5678, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'd0,         32'd1};
    vecs[2] = '{1'b0, 1'b0, 5'd31, 32'h0BAD_F00D, 5'd5,  5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 32'd2};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd2};
    vecs[4] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd7,  32'd0,         32'hA5A5_A5A5, 32'd3};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd0,  5'd5,  32'd0,         32'hDEAD_BEEF, 32'd3};
    vecs[6] = '{1'b1, 1'b1, 5'd9,  32'h0000_0042, 5'd9,  5'd5,  32'd0,         32'hDEAD_BEEF, 32'd3};
    vecs[7] = '{1'b0, 1'b0, 5'd9,  32'd0,         5'd9,  5'd5,  32'd0,         32'd0,         32'd0};
    vecs[8] = '{1'b0, 1'b1, 5'd28, 32'h1111_2222, 5'd28, 5'd29, 32'h1111_2222, 32'h0000_7FFC, 32'd0};
    vecs[9] = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd28, 5'd1,  32'h1111_2222, 32'd0,         32'd1};

    // Reset for one cycle, then read back every register.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("reset_count", write_count, 32'd0);
    for (int i = 0; i < 32; i += 2) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i + 1));
      check($sformatf("reset_r%0d", i), read_data_1,
            (i == 28) ? 32'h0000_1800 : 32'd0);
      check($sformatf("reset_r%0d", i + 1), read_data_2,
            (i + 1 == 29) ? 32'h0000_7FFC : 32'd0);
    end

    // Directed vector table, each checked before its own clock edge.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r1, vecs[v].r2);
      check($sformatf("vec%0d_rd1", v), read_data_1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), read_data_2, vecs[v].exp2);
      check($sformatf("vec%0d_cnt", v), write_count, vecs[v].expcnt);
    end

    // $0 stays zero in the cycle after an attempted write.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd28);
    check("zero_after_write", read_data_1, 32'd0);
    check("zero_write_cnt", write_count, 32'd1);

    // Randomized traffic against the array model, starting from reset.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    model_edge();
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), wr, $urandom(),
            ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
      check("rand_rd1", read_data_1, ref_read(read_reg_1));
      check("rand_rd2", read_data_2, ref_read(read_reg_2));
      check("rand_cnt", write_count, model_cnt);
      model_edge();
    end

    // Counter wrap: preload the count backdoor, then one more qualifying write.
    @(negedge clk);
    rst = 1'b0; reg_write = 1'b0;
    force dut.write_count = 32'hFFFF_FFFF;
    #1;
    release dut.write_count;
    drive(1'b0, 1'b1, 5'd3, 32'hCAFE_0003, 5'd3, 5'd3);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    check("wrap_cnt", write_count, 32'd0);
    check("wrap_data", read_data_1, 32'hCAFE_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
